// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 codes, FSM states, strobe patterns.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    // funct3[1:0] is the log2 access size for every load/store encoding
    function automatic logic [7:0] strb_base(input logic [1:0] size);
        case (size)
            2'b00:   return STRB_B;
            2'b01:   return STRB_H;
            2'b10:   return STRB_W;
            default: return STRB_D;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        case (size)
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo[1:0];
            2'b11:   return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: selects the addressed bytes of a doubleword and extends them.
module load_align
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [63:0] ldata
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    ldata = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    ldata = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    ldata = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   ldata = {56'd0, shifted[7:0]};
            F3_HU:   ldata = {48'd0, shifted[15:0]};
            F3_WU:   ldata = {32'd0, shifted[31:0]};
            default: ldata = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: issues doubleword dmem requests for loads/stores, aligns load data,
// and emits a one-cycle writeback record; non-memory results pass through in one cycle.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_addr,
    input  logic            reg_write,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            misalign_err,
    output logic            access_err
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [7:0]      wait_cnt;
    logic [2:0]      lo_addr;
    logic [2:0]      lo_f3;
    logic            is_load;
    logic            load_rw;
    logic            accept;
    logic            is_mem;
    logic            acc_bad;
    logic            mis_bad;
    logic [XLEN-1:0] ld_val;

    assign accept  = ex_valid & ex_ready;
    assign is_mem  = mem_read | mem_write;
    assign acc_bad = (mem_read & mem_write) | (mem_read ? (funct3 == 3'b111) : funct3[2]);
    assign mis_bad = is_misaligned(funct3[1:0], alu_result[2:0]);

    load_align u_align (
        .rdata   (dmem_rdata),
        .addr_lo (lo_addr),
        .funct3  (lo_f3),
        .ldata   (ld_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            lo_addr      <= 3'd0;
            lo_f3        <= 3'd0;
            is_load      <= 1'b0;
            load_rw      <= 1'b0;
            ex_ready     <= 1'b1;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= 8'd0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            misalign_err <= 1'b0;
            access_err   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            access_err   <= 1'b0;
            case (state)
                REQ: begin
                    if (dmem_ack) begin
                        state        <= RESP;
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        ex_ready     <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_data      <= is_load ? ld_val : '0;
                        wb_reg_write <= is_load & load_rw;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state        <= RESP;
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        ex_ready     <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_data      <= '0;
                        wb_reg_write <= 1'b0;
                        access_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                // IDLE and RESP both accept; RESP falls back to IDLE when nothing arrives
                default: begin
                    if (accept) begin
                        wb_rd   <= rd_addr;
                        lo_addr <= alu_result[2:0];
                        lo_f3   <= funct3;
                        is_load <= mem_read;
                        load_rw <= reg_write;
                        if (!is_mem) begin
                            state        <= IDLE;
                            ex_ready     <= 1'b0;
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_result;
                            wb_reg_write <= reg_write;
                        end else if (acc_bad || mis_bad) begin
                            state        <= IDLE;
                            ex_ready     <= 1'b0;
                            wb_valid     <= 1'b1;
                            wb_data      <= '0;
                            wb_reg_write <= 1'b0;
                            access_err   <= acc_bad;
                            misalign_err <= ~acc_bad;
                        end else begin
                            state      <= REQ;
                            ex_ready   <= 1'b0;
                            wait_cnt   <= 8'd0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_result[XLEN-1:3], 3'b000};
                            dmem_wdata <= mem_write ? (store_data << {alu_result[2:0], 3'b000}) : '0;
                            dmem_wstrb <= mem_write ? (strb_base(funct3[1:0]) << alu_result[2:0]) : 8'd0;
                        end
                    end else begin
                        state    <= IDLE;
                        ex_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: reference model feeds expected dmem requests and writebacks.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready;
    logic [63:0] alu_result, store_data;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, misalign_err, access_err;

    mem_access_unit #(.TIMEOUT(TO), .XLEN(64)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .rd_addr(rd_addr), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misalign_err(misalign_err), .access_err(access_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          chk_data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        acc;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        int          delay;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    bit       inject_late = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Drive one instruction, wait for acceptance, then record what the spec says must follow.
    task automatic issue(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd, input logic [4:0] rd,
                         input logic rw, input logic [63:0] rdata, input int delay);
        wb_exp_t     w;
        req_exp_t    q;
        int          nb, off, k;
        logic [63:0] mask, v;
        @(posedge clk); #1;
        ex_valid = 1; mem_read = rd_; mem_write = wr_; funct3 = f3;
        alu_result = a; store_data = sd; rd_addr = rd; reg_write = rw;
        k = 0;
        @(negedge clk);
        while (!ex_ready && k < 100) begin @(negedge clk); k++; end
        if (!ex_ready) begin
            fail("accept_timeout");
            ex_valid = 0;
            return;
        end
        @(posedge clk); #1;
        ex_valid = 0;
        w.rd = rd; w.chk_data = 1; w.mis = 0; w.acc = 0; w.rw = 0; w.data = 0;
        nb  = 1 << f3[1:0];
        off = int'(a[2:0]);
        if (!rd_ && !wr_) begin
            w.data = a; w.rw = rw;
        end else if ((rd_ && wr_) || (rd_ && f3 == 3'd7) || (wr_ && f3[2])) begin
            w.acc = 1; w.chk_data = 0;
        end else if (off % nb != 0) begin
            w.mis = 1; w.chk_data = 0;
        end else begin
            q.addr  = a - 64'(off);
            q.we    = wr_;
            q.wdata = sd << (8 * off);
            q.wstrb = 8'd0;
            for (int i = 0; i < nb; i++) q.wstrb[off + i] = 1'b1;
            q.rdata = rdata;
            q.delay = delay;
            req_q.push_back(q);
            if (delay >= TO) begin
                w.acc = 1; w.chk_data = rd_; w.data = 0;
            end else if (wr_) begin
                w.chk_data = 0;
            end else begin
                v = rdata >> (8 * off);
                if (nb < 8) begin
                    mask = (64'h1 << (8 * nb)) - 64'h1;
                    v = v & mask;
                    if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
                end
                w.data = v; w.rw = rw;
            end
        end
        wb_q.push_back(w);
    endtask

    task automatic drain();
        int k = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && k < 500) begin
            @(negedge clk); k++;
        end
        if (wb_q.size() != 0 || req_q.size() != 0) fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Writeback monitor
    wb_exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_q.size() == 0) fail("unexpected_wb");
                else begin
                    mon_e = wb_q.pop_front();
                    if (mon_e.chk_data) check("wb_data", wb_data, mon_e.data);
                    check("wb_rd", 64'(wb_rd), 64'(mon_e.rd));
                    check("wb_reg_write", 64'(wb_reg_write), 64'(mon_e.rw));
                    check("misalign_err", 64'(misalign_err), 64'(mon_e.mis));
                    check("access_err", 64'(access_err), 64'(mon_e.acc));
                end
            end else if (misalign_err || access_err) begin
                fail("err_without_wb");
            end
        end
    end

    // Memory responder: checks each request and acks after the planned delay
    req_exp_t cur;
    bit       busy = 0;
    int       reqcyc = 0;
    initial begin
        dmem_ack = 0; dmem_rdata = 0;
        forever begin
            @(negedge clk);
            dmem_ack = 0;
            if (dmem_req) begin
                if (!busy) begin
                    busy = 1; reqcyc = 0;
                    if (req_q.size() == 0) begin
                        fail("unexpected_req");
                        cur.addr = dmem_addr; cur.we = dmem_we; cur.delay = 0; cur.rdata = 0;
                    end else begin
                        cur = req_q.pop_front();
                        check("dmem_addr", dmem_addr, cur.addr);
                        check("dmem_we", 64'(dmem_we), 64'(cur.we));
                        if (cur.we) begin
                            check("dmem_wdata", dmem_wdata, cur.wdata);
                            check("dmem_wstrb", 64'(dmem_wstrb), 64'(cur.wstrb));
                        end
                    end
                end else begin
                    reqcyc++;
                    check("addr_stable", dmem_addr, cur.addr);
                end
                if (cur.delay == reqcyc) begin
                    dmem_ack = 1; dmem_rdata = cur.rdata;
                end
            end else begin
                if (busy && !reset && cur.delay >= TO)
                    check("req_high_cycles", 64'(reqcyc + 1), 64'(TO));
                busy = 0;
                if (inject_late) begin
                    dmem_ack = 1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; inject_late = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        int kind, nb;
        logic [2:0]  f3;
        logic [63:0] a;
        reset = 1; ex_valid = 0; alu_result = 0; store_data = 0;
        mem_read = 0; mem_write = 0; funct3 = 0; rd_addr = 0; reg_write = 0;
        #1;
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_dmem_req", 64'(dmem_req), 64'd0);
        check("rst_dmem_addr", dmem_addr, 64'd0);
        check("rst_dmem_wstrb", 64'(dmem_wstrb), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_errs", 64'({misalign_err, access_err}), 64'd0);
        #20;
        @(negedge clk); reset = 0;

        issue(0, 0, 3'd0, 64'h1234, 64'd0, 5'd5, 1, 64'd0, 0);
        issue(1, 0, 3'b000, 64'h1003, 64'd0, 5'd7, 1, 64'h0000_0000_8000_0000, 1);
        issue(1, 0, 3'b100, 64'h1003, 64'd0, 5'd7, 1, 64'h0000_0000_8000_0000, 0);
        issue(0, 1, 3'b010, 64'h2004, 64'hDEAD_BEEF, 5'd3, 1, 64'd0, 2);
        issue(1, 0, 3'b011, 64'h3001, 64'd0, 5'd9, 1, 64'd0, 0);
        issue(1, 0, 3'b011, 64'h40, 64'd0, 5'd10, 1, 64'h1111_2222_3333_4444, 99);
        drain();

        inject_late = 1;
        repeat (4) @(negedge clk);
        check("late_ack_ex_ready", 64'(ex_ready), 64'd1);
        check("late_ack_no_req", 64'(dmem_req), 64'd0);

        issue(1, 0, 3'b011, 64'h50, 64'd0, 5'd12, 1, 64'd0, 99);
        k = 0;
        while (!dmem_req && k < 20) begin @(negedge clk); k++; end
        if (!dmem_req) fail("no_req_before_reset");
        #2 reset = 1;
        #1;
        check("async_rst_req", 64'(dmem_req), 64'd0);
        check("async_rst_ready", 64'(ex_ready), 64'd1);
        wb_q.delete();
        req_q.delete();
        repeat (2) @(negedge clk);
        reset = 0;
        issue(1, 0, 3'b011, 64'h8, 64'd0, 5'd11, 1, 64'hCAFE_F00D_1234_5678, 1);
        drain();

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3[2] = (kind >= 3 && kind <= 6) ? f3[2] & ~(&f3[1:0]) : 1'b0;
            nb = 1 << f3[1:0];
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(nb - 1);
            issue(kind >= 3 && kind != 7 && kind != 8, kind >= 7, f3, a, {$urandom, $urandom},
                  5'($urandom), 1'($urandom), {$urandom, $urandom},
                  ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
